// File: rtl/snake_core.sv
// snake_core: snake movement, growth and collision engine with a
// registered cell-occupancy query port for the renderer.
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   state                 game FSM state (MAIN_* codes)
//   dir_up/down/left/right one-cycle direction pulses
//   food_x, food_y        food cell
//   food_valid            food cell is live
//   food_eaten            one-cycle pulse on growth
//   hit_wall, hit_body    sticky collision flags
//   win                   sticky win flag
//   head_x, head_y        current head cell
//   length                current segment count
//   q_x, q_y              renderer query cell
//   q_body, q_head        query result, one cycle later
//
// Optional feature: define SNAKE_WRAP_EN to wrap the head around the
// grid edges instead of raising hit_wall (hit_wall then stays 0).
module snake_core #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 12,
  parameter int MAX_LEN = 16,
  parameter int WIN_LEN = 12,
  parameter int T1      = 25_000_000,
  parameter int T2      = 12_500_000,
  parameter int T3      = 6_250_000,
  localparam int XW     = $clog2(GRID_W),
  localparam int YW     = $clog2(GRID_H),
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    state,
  input  logic          dir_up,
  input  logic          dir_down,
  input  logic          dir_left,
  input  logic          dir_right,
  input  logic [XW-1:0] food_x,
  input  logic [YW-1:0] food_y,
  input  logic          food_valid,
  output logic          food_eaten,
  output logic          hit_wall,
  output logic          hit_body,
  output logic          win,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [LW-1:0] length,
  input  logic [XW-1:0] q_x,
  input  logic [YW-1:0] q_y,
  output logic          q_body,
  output logic          q_head
);

  localparam logic [2:0] MAIN_START = 3'd0;
  localparam logic [2:0] MAIN_WAIT  = 3'd1;
  localparam logic [2:0] MAIN_GAME1 = 3'd2;
  localparam logic [2:0] MAIN_GAME2 = 3'd3;
  localparam logic [2:0] MAIN_GAME3 = 3'd4;

  localparam int T12  = (T1 > T2) ? T1 : T2;
  localparam int TMAX = (T12 > T3) ? T12 : T3;
  localparam int CW   = $clog2(TMAX + 1);

  // Opposite directions differ only in bit 0.
  typedef enum logic [1:0] {
    D_UP    = 2'd0,
    D_DOWN  = 2'd1,
    D_LEFT  = 2'd2,
    D_RIGHT = 2'd3
  } dir_t;

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];

  dir_t          dir;
  dir_t          pend_dir;
  dir_t          ref_dir;
  dir_t          cand;
  dir_t          pend_nxt;
  logic          cand_v;

  logic [CW-1:0] cnt;
  logic [CW-1:0] tn;
  logic          game;
  logic          init_st;
  logic          tick;

  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic          off;
  logic          wall;
  logic          grow;
  logic          body;
  logic [LW-1:0] len_nxt;

  logic          qb;
  logic          qh;

  assign head_x  = seg_x[0];
  assign head_y  = seg_y[0];
  assign init_st = (state == MAIN_START) ||
                   (state == MAIN_WAIT);

  always_comb begin
    game = 1'b0;
    tn   = CW'(T1);
    case (state)
      MAIN_GAME1: begin
        game = 1'b1;
        tn   = CW'(T1);
      end
      MAIN_GAME2: begin
        game = 1'b1;
        tn   = CW'(T2);
      end
      MAIN_GAME3: begin
        game = 1'b1;
        tn   = CW'(T3);
      end
      default: ;
    endcase
    // >= keeps a level change mid-count from overrunning the period.
    tick = game && (cnt >= tn - CW'(1));
  end

  // A pulse on the tick cycle targets the next tick, so it is
  // checked against the direction the snake is about to take.
  always_comb begin
    cand   = D_RIGHT;
    cand_v = 1'b1;
    if (dir_up)         cand = D_UP;
    else if (dir_down)  cand = D_DOWN;
    else if (dir_left)  cand = D_LEFT;
    else if (dir_right) cand = D_RIGHT;
    else                cand_v = 1'b0;
    ref_dir  = tick ? pend_dir : dir;
    pend_nxt = pend_dir;
    if (cand_v && (cand != dir_t'(ref_dir ^ 2'b01)))
      pend_nxt = cand;
  end

  // Step the head; nx/ny always hold the wrapped cell, off flags
  // that the unwrapped cell would leave the grid.
  always_comb begin
    nx  = seg_x[0];
    ny  = seg_y[0];
    off = 1'b0;
    case (pend_dir)
      D_UP: begin
        off = (seg_y[0] == '0);
        ny  = off ? YW'(GRID_H - 1) : seg_y[0] - YW'(1);
      end
      D_DOWN: begin
        off = (seg_y[0] == YW'(GRID_H - 1));
        ny  = off ? '0 : seg_y[0] + YW'(1);
      end
      D_LEFT: begin
        off = (seg_x[0] == '0);
        nx  = off ? XW'(GRID_W - 1) : seg_x[0] - XW'(1);
      end
      default: begin
        off = (seg_x[0] == XW'(GRID_W - 1));
        nx  = off ? '0 : seg_x[0] + XW'(1);
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign wall = 1'b0;
`else
  assign wall = off;
`endif

  // The tail cell only blocks the head when growing, since otherwise
  // it vacates on this same move.
  always_comb begin
    grow = food_valid && (nx == food_x) && (ny == food_y);
    body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (((i < int'(length) - 1) ||
           (grow && (i == int'(length) - 1))) &&
          (seg_x[i] == nx) && (seg_y[i] == ny))
        body = 1'b1;
    end
    len_nxt = (grow && (length < LW'(MAX_LEN))) ?
              length + LW'(1) : length;
  end

  always_comb begin
    qb = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((i < int'(length)) &&
          (seg_x[i] == q_x) && (seg_y[i] == q_y))
        qb = 1'b1;
    end
    qh = (seg_x[0] == q_x) && (seg_y[0] == q_y);
  end

  // Query results track the live segments in every state; only
  // reset clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_body <= 1'b0;
      q_head <= 1'b0;
    end else begin
      q_body <= qb;
      q_head <= qh;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || init_st) begin
      length     <= LW'(3);
      dir        <= D_RIGHT;
      pend_dir   <= D_RIGHT;
      cnt        <= '0;
      hit_wall   <= 1'b0;
      hit_body   <= 1'b0;
      win        <= 1'b0;
      food_eaten <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= (i < 3) ? XW'(GRID_W / 2 - i) : '0;
        seg_y[i] <= (i < 3) ? YW'(GRID_H / 2) : '0;
      end
    end else begin
      food_eaten <= 1'b0;
      if (game) begin
        cnt      <= tick ? '0 : cnt + CW'(1);
        pend_dir <= pend_nxt;
        if (tick) begin
          dir <= pend_dir;
          if (wall) begin
            hit_wall <= 1'b1;
          end else if (body) begin
            hit_body <= 1'b1;
          end else begin
            seg_x[0] <= nx;
            seg_y[0] <= ny;
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            length <= len_nxt;
            if (grow)
              food_eaten <= 1'b1;
            if (len_nxt >= LW'(WIN_LEN))
              win <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_core.sv
// tb_snake_core: directed bench for snake_core with a queue-based
// reference model compared on every cycle.
module tb_snake_core;

  localparam int GW   = 16;
  localparam int GH   = 12;
  localparam int ML   = 16;
  localparam int WL   = 4;
  localparam int TT1  = 6;
  localparam int TT2  = 5;
  localparam int TT3  = 4;

  localparam logic [2:0] S_START = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_G1    = 3'd2;
  localparam logic [2:0] S_G2    = 3'd3;
  localparam logic [2:0] S_G3    = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;
  localparam logic [2:0] S_LOSE  = 3'd6;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] state;
  logic       dir_up, dir_down, dir_left, dir_right;
  logic [3:0] food_x;
  logic [3:0] food_y;
  logic       food_valid;
  logic       food_eaten;
  logic       hit_wall, hit_body, win;
  logic [3:0] head_x;
  logic [3:0] head_y;
  logic [4:0] length;
  logic [3:0] q_x;
  logic [3:0] q_y;
  logic       q_body, q_head;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  snake_core #(
    .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .WIN_LEN(WL),
    .T1(TT1), .T2(TT2), .T3(TT3)
  ) dut (
    .clk(clk), .rst(rst), .state(state),
    .dir_up(dir_up), .dir_down(dir_down),
    .dir_left(dir_left), .dir_right(dir_right),
    .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .food_eaten(food_eaten),
    .hit_wall(hit_wall), .hit_body(hit_body), .win(win),
    .head_x(head_x), .head_y(head_y), .length(length),
    .q_x(q_x), .q_y(q_y), .q_body(q_body), .q_head(q_head)
  );

  always #5 clk = ~clk;

  // Reference model: the snake is a queue of cells, head first.
  int mx[$];
  int my[$];
  int mdir, mpend, mcnt;
  bit mw, mb, mwin, mfe, mqb, mqh;
  int dx[4] = '{0, 0, -1, 1};
  int dy[4] = '{-1, 1, 0, 0};

  task automatic m_init();
    mx    = {GW/2, GW/2 - 1, GW/2 - 2};
    my    = {GH/2, GH/2, GH/2};
    mdir  = 3;
    mpend = 3;
    mcnt  = 0;
    mw    = 0;
    mb    = 0;
    mwin  = 0;
    mfe   = 0;
  endtask

  always @(posedge clk) begin
    int tn, nd, oldp, hx, hy, refd;
    bit tick, g, hb, off;
    if (!rst) begin
      m_init();
      mqb = 0;
      mqh = 0;
    end else begin
      mqb = 0;
      foreach (mx[i])
        if (mx[i] == int'(q_x) && my[i] == int'(q_y)) mqb = 1;
      mqh = (mx[0] == int'(q_x) && my[0] == int'(q_y));
      mfe = 0;
      if (state == S_START || state == S_WAIT) begin
        m_init();
      end else if (state == S_G1 || state == S_G2 ||
                   state == S_G3) begin
        tn = (state == S_G1) ? TT1 : (state == S_G2) ? TT2 : TT3;
        tick = (mcnt >= tn - 1);
        mcnt = tick ? 0 : mcnt + 1;
        refd = tick ? mpend : mdir;
        nd = -1;
        if (dir_up) nd = 0;
        else if (dir_down) nd = 1;
        else if (dir_left) nd = 2;
        else if (dir_right) nd = 3;
        oldp = mpend;
        if (nd >= 0 && !(dx[nd] == -dx[refd] && dy[nd] == -dy[refd]))
          mpend = nd;
        if (tick) begin
          mdir = oldp;
          hx = mx[0] + dx[oldp];
          hy = my[0] + dy[oldp];
          off = (hx < 0 || hx >= GW || hy < 0 || hy >= GH);
          if (off) begin
            mw = 1;
          end else begin
            g = food_valid && hx == int'(food_x) && hy == int'(food_y);
            hb = 0;
            for (int i = 1; i < mx.size(); i++)
              if ((i <= mx.size() - 2 || g) && mx[i] == hx && my[i] == hy)
                hb = 1;
            if (hb) begin
              mb = 1;
            end else begin
              mx.push_front(hx);
              my.push_front(hy);
              if (!(g && mx.size() <= ML)) begin
                void'(mx.pop_back());
                void'(my.pop_back());
              end
              if (g) mfe = 1;
              if (mx.size() >= WL) mwin = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ($isunknown({head_x, head_y, length, hit_wall, hit_body,
                      win, food_eaten, q_body, q_head}) ||
          int'(head_x) != mx[0] || int'(head_y) != my[0] ||
          int'(length) != mx.size() || hit_wall != mw ||
          hit_body != mb || win != mwin || food_eaten != mfe ||
          q_body != mqb || q_head != mqh) begin
        n_err++;
        $display("FAIL cycle t=%0t got head=(%0d,%0d) len=%0d w/b/win/fe=%b%b%b%b q=%b%b need head=(%0d,%0d) len=%0d w/b/win/fe=%b%b%b%b q=%b%b",
                 $time, head_x, head_y, length, hit_wall, hit_body,
                 win, food_eaten, q_body, q_head, mx[0], my[0],
                 mx.size(), mw, mb, mwin, mfe, mqb, mqh);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d need %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic go(input logic [2:0] s);
    state = S_START;
    food_valid = 1'b0;
    step(1);
    state = s;
  endtask

  initial begin
    rst = 1'b0;
    state = S_START;
    {dir_up, dir_down, dir_left, dir_right} = 4'b0;
    food_x = 4'd0;
    food_y = 4'd0;
    food_valid = 1'b0;
    q_x = 4'd0;
    q_y = 4'd0;
    step(2);
    rst = 1'b1;
    chk_en = 1'b1;
    chk("rst_head_x", int'(head_x), 8);
    chk("rst_head_y", int'(head_y), 6);
    chk("rst_len", int'(length), 3);
    chk("rst_flags", int'({hit_wall, hit_body, win, food_eaten}), 0);
    chk("rst_q", int'({q_body, q_head}), 0);

    q_x = 4'd7; q_y = 4'd6;
    step(1);
    chk("q76_body", int'(q_body), 1);
    chk("q76_head", int'(q_head), 0);
    q_x = 4'd8;
    step(1);
    chk("q86_both", int'({q_body, q_head}), 3);

    // Run right into the east wall.
    state = S_G3;
    step(3);
    chk("first_move_wait", int'(head_x), 8);
    step(1);
    chk("first_move", int'(head_x), 9);
    step(24);
    chk("at_edge", int'(head_x), 15);
    chk("no_wall_yet", int'(hit_wall), 0);
    step(4);
    chk("wall_hit", int'(hit_wall), 1);
    chk("wall_head", int'(head_x), 15);
    chk("wall_nobody", int'(hit_body), 0);
    state = S_LOSE;
    step(5);
    chk("lose_hold", int'(hit_wall), 1);

    // Eat food on the first tick; WIN_LEN = 4 triggers win.
    go(S_G3);
    food_x = 4'd9; food_y = 4'd6; food_valid = 1'b1;
    q_x = 4'd6; q_y = 4'd6;
    step(4);
    chk("eat_len", int'(length), 4);
    chk("eat_pulse", int'(food_eaten), 1);
    chk("eat_win", int'(win), 1);
    food_valid = 1'b0;
    step(1);
    chk("eat_pulse_end", int'(food_eaten), 0);
    chk("tail_kept", int'(q_body), 1);
    state = S_WIN;
    step(3);
    state = S_START;
    step(1);
    chk("restart_len", int'(length), 3);
    chk("restart_win", int'(win), 0);
    chk("restart_head", int'(head_x), 8);

    // Up then an ignored left reversal.
    go(S_G3);
    dir_up = 1'b1; step(1); dir_up = 1'b0;
    dir_left = 1'b1; step(1); dir_left = 1'b0;
    step(2);
    chk("turn_up_x", int'(head_x), 8);
    chk("turn_up_y", int'(head_y), 5);

    // Grow to 5, then loop back onto seg[3].
    go(S_G3);
    food_x = 4'd9; food_y = 4'd6; food_valid = 1'b1;
    step(4);
    food_x = 4'd10;
    step(4);
    chk("len5", int'(length), 5);
    food_valid = 1'b0;
    dir_up = 1'b1; step(1); dir_up = 1'b0; step(3);
    dir_left = 1'b1; step(1); dir_left = 1'b0; step(3);
    dir_down = 1'b1; step(1); dir_down = 1'b0; step(3);
    chk("body_hit", int'(hit_body), 1);
    chk("body_nowall", int'(hit_wall), 0);
    chk("body_frozen", int'({head_x, head_y}), 9 * 16 + 5);
    step(4);
    chk("body_frozen2", int'({head_x, head_y}), 9 * 16 + 5);
    state = S_LOSE;
    step(2);

    // Pulse on the tick edge applies to the following tick.
    go(S_G1);
    step(5);
    dir_down = 1'b1; step(1); dir_down = 1'b0;
    chk("g1_tick_x", int'(head_x), 9);
    chk("g1_tick_y", int'(head_y), 6);
    step(6);
    chk("g1_next_y", int'(head_y), 7);

    // Simultaneous up+down: up wins.
    go(S_G2);
    dir_up = 1'b1; dir_down = 1'b1; step(1);
    dir_up = 1'b0; dir_down = 1'b0;
    step(4);
    chk("prio_up", int'(head_y), 5);
    state = S_WAIT;
    step(1);
    chk("wait_init", int'(head_y), 6);

    // Reset mid-game.
    state = S_G3;
    step(4);
    rst = 1'b0;
    step(1);
    chk("midrst_head", int'(head_x), 8);
    chk("midrst_q", int'(q_body), 0);
    rst = 1'b1;
    state = S_START;
    step(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
